// File: rtl/aes_cipher_ctrl_pkg.sv
// Shared constants, state encoding and helpers for the AES cipher controller.
package aes_cipher_ctrl_pkg;

    localparam int AES_NR_MAX     = 14;
    localparam int BLK_S          = 128;
    localparam int Nb             = 4;
    localparam int ROUND_KEY_BITS = 128;

    localparam logic [3:0] RNDS_RESET = 4'd10;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_OUT  = 2'd2
    } ctrl_state_t;

    function automatic logic rounds_valid(input logic [3:0] nr);
        return (nr == 4'd10) || (nr == 4'd12) || (nr == 4'd14);
    endfunction

endpackage

// File: rtl/aes_rkey_ram.sv
// Round-key store: (NR_MAX+1) x 128 RAM, synchronous write, registered read.
module aes_rkey_ram
    import aes_cipher_ctrl_pkg::*;
#(
    parameter int NR_MAX = AES_NR_MAX
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic                      i_wr_en,
    input  logic [3:0]                i_wr_addr,
    input  logic [ROUND_KEY_BITS-1:0] i_wr_data,
    input  logic [3:0]                i_rd_addr,
    output logic [ROUND_KEY_BITS-1:0] o_rd_data
);

    localparam logic [3:0] LAST_ADDR = 4'(NR_MAX);

    logic [ROUND_KEY_BITS-1:0] r_mem [0:NR_MAX];
    logic [ROUND_KEY_BITS-1:0] r_rd_data;

    // Array contents are intentionally not reset; keys survive a controller reset.
    always_ff @(posedge clk) begin
        if (i_wr_en && (i_wr_addr <= LAST_ADDR)) begin
            r_mem[i_wr_addr] <= i_wr_data;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_rd_data <= '0;
        end else if (i_rd_addr <= LAST_ADDR) begin
            r_rd_data <= r_mem[i_rd_addr];
        end else begin
            r_rd_data <= '0;
        end
    end

    assign o_rd_data = r_rd_data;

endmodule

// File: rtl/aes_cipher_ctrl.sv
// Stream front-end and one-block-in-flight sequencer for the AES round engine.
// Optional CBC chaining is built when AES_CTRL_CBC_EN is defined (ECB otherwise).
//
// state   | meaning
// IDLE    | ready for a plaintext block and round-key writes
// RUN     | block launched on the engine, waiting for its done pulse
// OUT     | ciphertext presented, waiting for the output handshake
module aes_cipher_ctrl
    import aes_cipher_ctrl_pkg::*;
#(
    parameter int NR_MAX = AES_NR_MAX
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         i_rk_wr_en,
    input  logic [3:0]   i_rk_wr_addr,
    input  logic [127:0] i_rk_wr_data,
    input  logic [3:0]   i_cfg_rounds,
    input  logic         i_iv_load,
    input  logic [127:0] i_cfg_iv,
    input  logic         i_s_valid,
    output logic         o_s_ready,
    input  logic [127:0] i_s_data,
    output logic         o_m_valid,
    input  logic         i_m_ready,
    output logic [127:0] o_m_data,
    output logic         o_busy,
    output logic         o_cfg_err,
    output logic         o_core_en,
    output logic [127:0] o_core_plaintext,
    output logic [3:0]   o_core_rounds,
    output logic [127:0] o_core_key,
    input  logic [3:0]   i_core_round_key_no,
    input  logic [127:0] i_core_ciphertext,
    input  logic         i_core_en_o
);

    localparam logic [3:0] LAST_ADDR = 4'(NR_MAX);

    ctrl_state_t  r_state;
    ctrl_state_t  w_state_next;
    logic         r_core_en;
    logic         r_wr_err;
    logic [127:0] r_pt;
    logic [3:0]   r_rounds;
    logic [127:0] r_m_data;
    logic [127:0] w_pt_in;
    logic         w_cfg_err;
    logic         w_wr_ok;
    logic         w_s_hs;
    logic         w_m_hs;
    logic         w_done;

    assign w_wr_ok   = i_rk_wr_en && (r_state == ST_IDLE) && (i_rk_wr_addr <= LAST_ADDR);
    assign w_cfg_err = !reset && (!rounds_valid(i_cfg_rounds) || r_wr_err);
    assign w_s_hs    = i_s_valid && o_s_ready;
    assign w_m_hs    = (r_state == ST_OUT) && i_m_ready;
    assign w_done    = (r_state == ST_RUN) && i_core_en_o;

`ifdef AES_CTRL_CBC_EN
    logic [127:0] r_chain;

    assign w_pt_in = i_s_data ^ r_chain;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_chain <= '0;
        end else if (w_done) begin
            r_chain <= i_core_ciphertext;
        end else if (i_iv_load && (r_state == ST_IDLE)) begin
            r_chain <= i_cfg_iv;
        end
    end
`else
    logic w_unused_iv;

    assign w_pt_in     = i_s_data;
    assign w_unused_iv = ^{i_iv_load, i_cfg_iv};
`endif

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            ST_IDLE: if (w_s_hs) w_state_next = ST_RUN;
            ST_RUN:  if (w_done) w_state_next = ST_OUT;
            ST_OUT:  if (w_m_hs) w_state_next = ST_IDLE;
            default: w_state_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state   <= ST_IDLE;
            r_core_en <= 1'b0;
            r_wr_err  <= 1'b0;
            r_pt      <= '0;
            r_rounds  <= RNDS_RESET;
            r_m_data  <= '0;
        end else begin
            r_state   <= w_state_next;
            r_core_en <= w_s_hs;
            r_wr_err  <= i_rk_wr_en && !w_wr_ok;
            if (w_s_hs) begin
                r_pt     <= w_pt_in;
                r_rounds <= i_cfg_rounds;
            end
            if (w_done) begin
                r_m_data <= i_core_ciphertext;
            end
        end
    end

    aes_rkey_ram #(.NR_MAX(NR_MAX)) u_rkey_ram (
        .clk       (clk),
        .reset     (reset),
        .i_wr_en   (w_wr_ok),
        .i_wr_addr (i_rk_wr_addr),
        .i_wr_data (i_rk_wr_data),
        .i_rd_addr (i_core_round_key_no),
        .o_rd_data (o_core_key)
    );

    assign o_s_ready        = !reset && (r_state == ST_IDLE) && !w_cfg_err;
    assign o_m_valid        = (r_state == ST_OUT);
    assign o_m_data         = r_m_data;
    assign o_busy           = (r_state != ST_IDLE);
    assign o_cfg_err        = w_cfg_err;
    assign o_core_en        = r_core_en;
    assign o_core_plaintext = r_pt;
    assign o_core_rounds    = r_rounds;

endmodule

// File: tb/tb_aes_cipher_ctrl.sv
// Bench for aes_cipher_ctrl: a behavioural AES round engine sits on the core_* ports.
module tb_aes_cipher_ctrl;

    logic         clk = 1'b0;
    logic         reset;
    logic         rk_wr_en;
    logic [3:0]   rk_wr_addr;
    logic [127:0] rk_wr_data;
    logic [3:0]   cfg_rounds;
    logic         iv_load;
    logic [127:0] cfg_iv;
    logic         s_valid;
    logic         s_ready;
    logic [127:0] s_data;
    logic         m_valid;
    logic         m_ready;
    logic [127:0] m_data;
    logic         busy;
    logic         cfg_err;
    logic         core_en;
    logic [127:0] core_plaintext;
    logic [3:0]   core_rounds;
    logic [127:0] core_key;
    logic [3:0]   core_round_key_no;
    logic [127:0] core_ciphertext;
    logic         core_en_o;

    int checks   = 0;
    int failures = 0;

    logic [127:0] exp_rk [0:14];

    localparam logic [127:0] FIPS_PT  = 128'h00112233445566778899aabbccddeeff;
    localparam logic [127:0] FIPS_CT1 = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
    localparam logic [127:0] FIPS_CT2 = 128'h8ea2b7ca516745bfeafc49904b496089;

    always #5 clk = ~clk;

    aes_cipher_ctrl #(.NR_MAX(14)) dut (
        .clk                 (clk),
        .reset               (reset),
        .i_rk_wr_en          (rk_wr_en),
        .i_rk_wr_addr        (rk_wr_addr),
        .i_rk_wr_data        (rk_wr_data),
        .i_cfg_rounds        (cfg_rounds),
        .i_iv_load           (iv_load),
        .i_cfg_iv            (cfg_iv),
        .i_s_valid           (s_valid),
        .o_s_ready           (s_ready),
        .i_s_data            (s_data),
        .o_m_valid           (m_valid),
        .i_m_ready           (m_ready),
        .o_m_data            (m_data),
        .o_busy              (busy),
        .o_cfg_err           (cfg_err),
        .o_core_en           (core_en),
        .o_core_plaintext    (core_plaintext),
        .o_core_rounds       (core_rounds),
        .o_core_key          (core_key),
        .i_core_round_key_no (core_round_key_no),
        .i_core_ciphertext   (core_ciphertext),
        .i_core_en_o         (core_en_o)
    );

    function automatic logic [7:0] xt(input logic [7:0] b);
        return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
    endfunction

    function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p;
        logic [7:0] x;
        p = 8'h00;
        x = a;
        for (int i = 0; i < 8; i++) begin
            if (b[i]) p = p ^ x;
            x = xt(x);
        end
        return p;
    endfunction

    // S-box from the GF(2^8) inverse (x^254) followed by the affine map.
    function automatic logic [7:0] sbox(input logic [7:0] x);
        logic [7:0] p;
        logic [7:0] r;
        p = x;
        r = 8'h01;
        for (int k = 1; k < 8; k++) begin
            p = gmul(p, p);
            r = gmul(r, p);
        end
        return r ^ {r[6:0], r[7]} ^ {r[5:0], r[7:6]} ^ {r[4:0], r[7:5]} ^ {r[3:0], r[7:4]} ^ 8'h63;
    endfunction

    function automatic logic [31:0] subw(input logic [31:0] w);
        return {sbox(w[31:24]), sbox(w[23:16]), sbox(w[15:8]), sbox(w[7:0])};
    endfunction

    function automatic logic [127:0] aes_round(input logic [127:0] st, input logic [127:0] key,
                                               input logic last);
        logic [7:0]   a [16];
        logic [7:0]   b [16];
        logic [7:0]   c0, c1, c2, c3;
        logic [127:0] o;
        for (int i = 0; i < 16; i++) a[i] = sbox(st[127-8*i -: 8]);
        for (int c = 0; c < 4; c++)
            for (int r = 0; r < 4; r++)
                b[r+4*c] = a[r+4*((c+r)%4)];
        if (!last) begin
            for (int c = 0; c < 4; c++) begin
                c0 = b[4*c]; c1 = b[4*c+1]; c2 = b[4*c+2]; c3 = b[4*c+3];
                b[4*c]   = xt(c0) ^ xt(c1) ^ c1 ^ c2 ^ c3;
                b[4*c+1] = c0 ^ xt(c1) ^ xt(c2) ^ c2 ^ c3;
                b[4*c+2] = c0 ^ c1 ^ xt(c2) ^ xt(c3) ^ c3;
                b[4*c+3] = xt(c0) ^ c0 ^ c1 ^ c2 ^ xt(c3);
            end
        end
        for (int i = 0; i < 16; i++) o[127-8*i -: 8] = b[i];
        return o ^ key;
    endfunction

    task automatic expand_key(input logic [255:0] key, input int nk, input int nr);
        logic [31:0] w [0:59];
        logic [31:0] t;
        logic [7:0]  rc;
        rc = 8'h01;
        for (int i = 0; i < nk; i++) w[i] = key[255-32*i -: 32];
        for (int i = nk; i < 4*(nr+1); i++) begin
            t = w[i-1];
            if (i % nk == 0) begin
                t  = subw({t[23:0], t[31:24]}) ^ {rc, 24'h0};
                rc = xt(rc);
            end else if (nk > 6 && i % nk == 4) begin
                t = subw(t);
            end
            w[i] = w[i-nk] ^ t;
        end
        for (int r = 0; r <= nr; r++) exp_rk[r] = {w[4*r], w[4*r+1], w[4*r+2], w[4*r+3]};
    endtask

    // Round engine: key k is requested in cycle S+k, done pulse at S+Nr+3.
    initial begin : engine
        logic [127:0] e_state;
        int           e_nr;
        int           e_cnt;
        bit           e_busy;
        core_en_o         = 1'b0;
        core_ciphertext   = '0;
        core_round_key_no = 4'd0;
        e_busy            = 1'b0;
        e_state           = '0;
        e_nr              = 0;
        e_cnt             = 0;
        forever begin
            @(posedge clk);
            #1;
            core_en_o = 1'b0;
            if (reset) begin
                e_busy            = 1'b0;
                core_round_key_no = 4'd0;
            end else if (!e_busy) begin
                if (core_en) begin
                    e_busy            = 1'b1;
                    e_state           = core_plaintext;
                    e_nr              = int'(core_rounds);
                    e_cnt             = 0;
                    core_round_key_no = 4'd0;
                end
            end else begin
                e_cnt++;
                if (e_cnt == 1) e_state = e_state ^ core_key;
                else if (e_cnt <= e_nr + 1) e_state = aes_round(e_state, core_key, e_cnt == e_nr + 1);
                if (e_cnt <= e_nr) core_round_key_no = 4'(e_cnt);
                if (e_cnt == e_nr + 3) begin
                    core_en_o       = 1'b1;
                    core_ciphertext = e_state;
                    e_busy          = 1'b0;
                end
            end
        end
    end

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic load_keys(input int nr);
        for (int r = 0; r <= nr; r++) begin
            rk_wr_en   = 1'b1;
            rk_wr_addr = 4'(r);
            rk_wr_data = exp_rk[r];
            tick();
        end
        rk_wr_en = 1'b0;
    endtask

    task automatic set_iv(input logic [127:0] iv);
        iv_load = 1'b1;
        cfg_iv  = iv;
        tick();
        iv_load = 1'b0;
    endtask

    task automatic accept(input logic [127:0] pt, input logic [3:0] nr);
        int n;
        n          = 0;
        cfg_rounds = nr;
        s_data     = pt;
        s_valid    = 1'b1;
        while (!s_ready && n < 50) begin
            tick();
            n++;
        end
        tick();
        s_valid = 1'b0;
    endtask

    task automatic wait_out(input int start, output int lat, output int en_cnt);
        lat    = start;
        en_cnt = 0;
        while (!m_valid && lat < 100) begin
            if (core_en) en_cnt++;
            tick();
            lat++;
        end
    endtask

    task automatic pop;
        m_ready = 1'b1;
        tick();
        m_ready = 1'b0;
    endtask

    task automatic test_reset;
        reset = 1'b1;
        tick();
        tick();
        checks++; if (s_ready !== 1'b0) begin failures++; $display("FAIL rst_s_ready got=%b exp=0", s_ready); end
        checks++; if (m_valid !== 1'b0) begin failures++; $display("FAIL rst_m_valid got=%b exp=0", m_valid); end
        checks++; if (busy !== 1'b0) begin failures++; $display("FAIL rst_busy got=%b exp=0", busy); end
        checks++; if (core_en !== 1'b0) begin failures++; $display("FAIL rst_core_en got=%b exp=0", core_en); end
        checks++; if (cfg_err !== 1'b0) begin failures++; $display("FAIL rst_cfg_err got=%b exp=0", cfg_err); end
        checks++; if (m_data !== 128'h0) begin failures++; $display("FAIL rst_m_data got=%h exp=0", m_data); end
        checks++; if (core_plaintext !== 128'h0) begin failures++; $display("FAIL rst_pt got=%h exp=0", core_plaintext); end
        checks++; if (core_key !== 128'h0) begin failures++; $display("FAIL rst_core_key got=%h exp=0", core_key); end
        checks++; if (core_rounds !== 4'd10) begin failures++; $display("FAIL rst_rounds got=%0d exp=10", core_rounds); end
        reset = 1'b0;
        tick();
        checks++; if (s_ready !== 1'b1) begin failures++; $display("FAIL post_rst_s_ready got=%b exp=1", s_ready); end
    endtask

    task automatic test_aes128;
        int lat, en;
        expand_key({128'h000102030405060708090a0b0c0d0e0f, 128'h0}, 4, 10);
        load_keys(10);
        set_iv(128'h0);
        accept(FIPS_PT, 4'd10);
        wait_out(1, lat, en);
        checks++; if (lat != 15) begin failures++; $display("FAIL aes128_latency got=%0d exp=15", lat); end
        checks++; if (en != 1) begin failures++; $display("FAIL aes128_core_en_cycles got=%0d exp=1", en); end
        checks++; if (m_data !== FIPS_CT1) begin failures++; $display("FAIL aes128_ct got=%h exp=%h", m_data, FIPS_CT1); end
        checks++; if (core_rounds !== 4'd10) begin failures++; $display("FAIL aes128_rounds got=%0d exp=10", core_rounds); end
        pop();
        checks++; if (s_ready !== 1'b1) begin failures++; $display("FAIL aes128_s_ready_after got=%b exp=1", s_ready); end
    endtask

    task automatic test_aes256;
        int lat, en;
        expand_key(256'h000102030405060708090a0b0c0d0e0f101112131415161718191a1b1c1d1e1f, 8, 14);
        load_keys(14);
        set_iv(128'h0);
        accept(FIPS_PT, 4'd14);
        wait_out(1, lat, en);
        checks++; if (lat != 19) begin failures++; $display("FAIL aes256_latency got=%0d exp=19", lat); end
        checks++; if (m_data !== FIPS_CT2) begin failures++; $display("FAIL aes256_ct got=%h exp=%h", m_data, FIPS_CT2); end
        pop();
    endtask

    task automatic test_backpressure;
        int lat, en;
        expand_key({128'h000102030405060708090a0b0c0d0e0f, 128'h0}, 4, 10);
        load_keys(10);
        set_iv(128'h0);
        accept(FIPS_PT, 4'd10);
        wait_out(1, lat, en);
        for (int i = 0; i < 20; i++) begin
            tick();
            checks++; if (m_data !== FIPS_CT1) begin failures++; $display("FAIL bp_m_data cyc=%0d got=%h exp=%h", i, m_data, FIPS_CT1); end
            checks++; if (s_ready !== 1'b0 || busy !== 1'b1 || m_valid !== 1'b1) begin
                failures++; $display("FAIL bp_flags cyc=%0d got s_ready=%b busy=%b m_valid=%b exp 0/1/1", i, s_ready, busy, m_valid);
            end
        end
        pop();
        checks++; if (s_ready !== 1'b1 || m_valid !== 1'b0) begin
            failures++; $display("FAIL bp_release got s_ready=%b m_valid=%b exp 1/0", s_ready, m_valid);
        end
    endtask

    task automatic test_key_write_busy;
        int lat, en;
        set_iv(128'h0);
        accept(FIPS_PT, 4'd10);
        rk_wr_en   = 1'b1;
        rk_wr_addr = 4'd0;
        rk_wr_data = 128'hdeadbeef_deadbeef_deadbeef_deadbeef;
        tick();
        rk_wr_en = 1'b0;
        checks++; if (cfg_err !== 1'b1) begin failures++; $display("FAIL busy_wr_err_pulse got=%b exp=1", cfg_err); end
        tick();
        checks++; if (cfg_err !== 1'b0) begin failures++; $display("FAIL busy_wr_err_clear got=%b exp=0", cfg_err); end
        wait_out(3, lat, en);
        checks++; if (m_data !== FIPS_CT1) begin failures++; $display("FAIL busy_wr_ct1 got=%h exp=%h", m_data, FIPS_CT1); end
        pop();
        accept(FIPS_PT, 4'd10);
        wait_out(1, lat, en);
        checks++; if (m_data !== FIPS_CT1) begin failures++; $display("FAIL busy_wr_ct2 got=%h exp=%h", m_data, FIPS_CT1); end
        pop();
        rk_wr_en   = 1'b1;
        rk_wr_addr = 4'd15;
        rk_wr_data = 128'h0;
        tick();
        rk_wr_en = 1'b0;
        checks++; if (cfg_err !== 1'b1) begin failures++; $display("FAIL addr_oor_err got=%b exp=1", cfg_err); end
        tick();
        checks++; if (cfg_err !== 1'b0) begin failures++; $display("FAIL addr_oor_clear got=%b exp=0", cfg_err); end
    endtask

    task automatic test_bad_rounds;
        cfg_rounds = 4'd11;
        s_data     = FIPS_PT;
        s_valid    = 1'b1;
        #1;
        checks++; if (s_ready !== 1'b0) begin failures++; $display("FAIL nr11_s_ready got=%b exp=0", s_ready); end
        checks++; if (cfg_err !== 1'b1) begin failures++; $display("FAIL nr11_cfg_err got=%b exp=1", cfg_err); end
        tick();
        tick();
        tick();
        checks++; if (busy !== 1'b0) begin failures++; $display("FAIL nr11_busy got=%b exp=0", busy); end
        s_valid    = 1'b0;
        cfg_rounds = 4'd10;
        #1;
        checks++; if (cfg_err !== 1'b0 || s_ready !== 1'b1) begin
            failures++; $display("FAIL nr10_restore got cfg_err=%b s_ready=%b exp 0/1", cfg_err, s_ready);
        end
    endtask

    task automatic test_reset_mid_run;
        int lat, en;
        bit seen;
        accept(FIPS_PT, 4'd10);
        tick();
        tick();
        reset = 1'b1;
        tick();
        tick();
        reset = 1'b0;
        checks++; if (busy !== 1'b0) begin failures++; $display("FAIL midrst_busy got=%b exp=0", busy); end
        seen = 1'b0;
        for (int i = 0; i < 30; i++) begin
            if (m_valid) seen = 1'b1;
            tick();
        end
        checks++; if (seen) begin failures++; $display("FAIL midrst_m_valid got=1 exp=0"); end
        accept(FIPS_PT, 4'd10);
        wait_out(1, lat, en);
        checks++; if (m_data !== FIPS_CT1 || lat != 15) begin
            failures++; $display("FAIL midrst_next got=%h lat=%0d exp=%h lat=15", m_data, lat, FIPS_CT1);
        end
        pop();
    endtask

`ifdef AES_CTRL_CBC_EN
    task automatic test_cbc;
        int lat, en;
        expand_key({128'h2b7e151628aed2a6abf7158809cf4f3c, 128'h0}, 4, 10);
        load_keys(10);
        set_iv(128'h000102030405060708090a0b0c0d0e0f);
        accept(128'h6bc1bee22e409f96e93d7e117393172a, 4'd10);
        wait_out(1, lat, en);
        checks++; if (m_data !== 128'h7649abac8119b246cee98e9b12e9197d) begin
            failures++; $display("FAIL cbc_blk1 got=%h exp=7649abac8119b246cee98e9b12e9197d", m_data);
        end
        pop();
        accept(128'hae2d8a571e03ac9c9eb76fac45af8e51, 4'd10);
        wait_out(1, lat, en);
        checks++; if (m_data !== 128'h5086cb9b507219ee95db113a917678b2) begin
            failures++; $display("FAIL cbc_blk2 got=%h exp=5086cb9b507219ee95db113a917678b2", m_data);
        end
        pop();
    endtask
`else
    task automatic test_iv_ignored;
        int lat, en;
        set_iv(128'hffffffff_ffffffff_ffffffff_ffffffff);
        accept(FIPS_PT, 4'd10);
        wait_out(1, lat, en);
        checks++; if (m_data !== FIPS_CT1) begin failures++; $display("FAIL ecb_iv_ignored got=%h exp=%h", m_data, FIPS_CT1); end
        pop();
    endtask
`endif

    initial begin
        reset      = 1'b1;
        rk_wr_en   = 1'b0;
        rk_wr_addr = 4'd0;
        rk_wr_data = '0;
        cfg_rounds = 4'd10;
        iv_load    = 1'b0;
        cfg_iv     = '0;
        s_valid    = 1'b0;
        s_data     = '0;
        m_ready    = 1'b0;
        test_reset();
        test_aes128();
        test_aes256();
        test_backpressure();
        test_key_write_busy();
        test_bad_rounds();
        test_reset_mid_run();
`ifdef AES_CTRL_CBC_EN
        test_cbc();
`else
        test_iv_ignored();
`endif
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
